// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Digits are registered and held between conversions so the display never flickers.
module bcd_converter_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ten_thousands,
  output logic [3:0]       thousands,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] bin_reg;
  logic [19:0]      scratch;
  logic [CW-1:0]    cnt;
  logic [19:0]      scratch_adj;
  logic [19:0]      scratch_shifted;
  logic             last_bit;
  logic             accept;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // All five nibbles are corrected on pre-shift values, then the binary MSB shifts in.
  always_comb begin
    scratch_adj     = {add3(scratch[19:16]), add3(scratch[15:12]), add3(scratch[11:8]),
                       add3(scratch[7:4]), add3(scratch[3:0])};
    scratch_shifted = (scratch_adj << 1) | {19'd0, bin_reg[WIDTH-1]};
    last_bit        = (cnt == CW'(WIDTH - 1));
    accept          = start && (state != SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_reg <= '0;
      scratch <= '0;
      cnt     <= '0;
    end else if (accept) begin
      bin_reg <= bin;
      scratch <= '0;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      bin_reg <= bin_reg << 1;
      scratch <= scratch_shifted;
      cnt     <= cnt + CW'(1);
    end
  end

  // Digits only move on the final shift edge, so ignored starts cannot disturb them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ten_thousands <= 4'd0;
      thousands     <= 4'd0;
      hundreds      <= 4'd0;
      tens          <= 4'd0;
      ones          <= 4'd0;
      overflow      <= 1'b0;
    end else if (state == SHIFT && last_bit) begin
      ten_thousands <= scratch_shifted[19:16];
      thousands     <= scratch_shifted[15:12];
      hundreds      <= scratch_shifted[11:8];
      tens          <= scratch_shifted[7:4];
      ones          <= scratch_shifted[3:0];
      overflow      <= (scratch_shifted[19:16] != 4'd0);
    end
  end

endmodule
